proc_ctrl_fsm: RTL and testbench
================================

Name: proc_ctrl_fsm

Overview:
Multi-cycle control unit for the basic processor. Sequences fetch, decode, execute, memory and writeback for the 3-bit opcode ISA (ADD, LSH, RSH, XOR, LD, SW, BNE, plus HALT on 3'b111). Sits between instruction ROM / data memory and the PC, register file and ALU. It drives every datapath enable, handshakes with data memory, and counts retired instructions.

Parameters:
IW, 9, instruction width; opcode is instr[IW-1:IW-3]
MEM_TIMEOUT, 8, max MEM-state cycles waiting for mem_ack before fault (>=1)
CW, 16, retired-instruction counter width

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  leave IDLE/HALT and begin fetching
instr  in  IW  instruction ROM output at current PC, valid combinationally
zero  in  1  ALU zero flag, valid during EXEC
mem_ack  in  1  data memory done, sampled each MEM cycle
ir_load  out  1  latch instr into IR
pc_inc  out  1  PC <= PC+1
pc_load  out  1  PC <= branch target
alu_op  out  3  ALU operation select
rf_we  out  1  register file write enable
wb_sel  out  1  writeback mux: 0 = ALU, 1 = memory
mem_req  out  1  data memory request, held until ack
mem_we  out  1  store qualifier, valid with mem_req
busy  out  1  state not IDLE/HALT/FAULT
done  out  1  in HALT
fault  out  1  in FAULT (sticky)
state  out  3  current state encoding (debug)
retired  out  CW  instructions completed, wraps modulo 2^CW

Behaviour:
- Reset (async, Reset=0): state=IDLE, opcode reg=0, timer=0, retired=0; all outputs 0; alu_op=000.
- Outputs decode combinationally from the state register and the latched opcode only. No path runs from start or mem_ack to outputs, except pc_load, which depends on zero in EXEC.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- IDLE: start=1 -> FETCH.
- FETCH: ir_load=1, pc_inc=1; latch opcode from instr; -> DECODE.
- DECODE: opcode 111 -> HALT; else -> EXEC.
- EXEC:
  - opcodes 000-011: alu_op=opcode; -> WB.
  - LD/SW: alu_op=000; -> MEM; timer cleared.
  - BNE: alu_op=011 (XOR compare); pc_load = ~zero; -> FETCH; retired+1.
- MEM: mem_req=1; mem_we=1 for SW.
  - mem_ack=1 (ack may arrive in the first MEM cycle): LD -> WB; SW -> FETCH with retired+1.
  - mem_ack=0: timer+1; if timer reaches MEM_TIMEOUT-1 this cycle -> FAULT.
- WB: rf_we=1; wb_sel=1 for LD, else 0; -> FETCH; retired+1.
- HALT: done=1; start=1 -> FETCH (PC untouched; resumes after HALT instruction).
- FAULT: fault=1; exit only by Reset.
- start is ignored in every state other than IDLE/HALT.
- Latency:
  - ALU op: 4 cycles (F,D,E,WB).
  - BNE: 3 cycles.
  - SW: 4 + wait cycles.
  - LD: 5 + wait cycles, where wait = MEM cycles without ack.
- Reset asserted mid-instruction aborts it immediately. No partial retire; no rf_we/mem_req is issued after release until a new start.
- retired counts only completed instructions; HALT is not counted; wraps to 0.

Decomposition:
- Shared package definitions gains:
  - kHALT = 3'b111 and HALT in op_mne.
  - ctrl_state_e enum (IDLE=0, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT).
  - kWB_ALU/kWB_MEM constants.
- One sub-module, mem_wait_timer: clear/enable counter with an expired output, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset low mid-run -> all outputs 0, state=0, retired=0. After release, no activity until start.
- start; ROM {XOR r1,r2}: ir_load/pc_inc in cycle 1, alu_op=011 in cycle 3, rf_we with wb_sel=0 in cycle 4, retired=1.
- LD with mem_ack after 2 cycles -> mem_req high for 3 cycles, mem_we=0, then WB with wb_sel=1, rf_we=1; 7 cycles total.
- SW with ack in first MEM cycle -> mem_req=mem_we=1 for 1 cycle, rf_we never asserted, next state FETCH.
- BNE with zero=0 -> pc_load=1 in EXEC; with zero=1 -> pc_load=0; both return to FETCH after 3 cycles.
- LD with mem_ack held 0, MEM_TIMEOUT=8 -> fault=1 after 8 MEM cycles and stays set through start=1. Opcode 111 -> done=1; start resumes at FETCH.

Source files
------------

// File: rtl/proc_ctrl_fsm_pkg.sv
// Shared types for the multi-cycle processor control unit: opcodes, controller
// states and writeback/ALU select constants.
package proc_ctrl_fsm_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_LSH  = 3'b001,
      OP_RSH  = 3'b010,
      OP_XOR  = 3'b011,
      OP_LD   = 3'b100,
      OP_SW   = 3'b101,
      OP_BNE  = 3'b110,
      OP_HALT = 3'b111
   } op_mne;

   localparam logic [2:0] kHALT = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_FAULT  = 3'd7
   } ctrl_state_e;

   localparam logic kWB_ALU = 1'b0;
   localparam logic kWB_MEM = 1'b1;

   localparam logic [2:0] kALU_ADD = 3'b000;
   localparam logic [2:0] kALU_XOR = 3'b011;

   // Opcodes 000-011 are register-to-register ALU operations.
   function automatic logic isAluOp(op_mne op);
      return ~op[2];
   endfunction

endpackage

// File: rtl/proc_ctrl_fsm_if.sv
// Control-unit bundle: inputs from ROM/ALU/memory, enables out to the datapath.
interface proc_ctrl_fsm_if #(
   parameter int IW = 9,
   parameter int CW = 16
);
   logic          start;
   logic [IW-1:0] instr;
   logic          zero;
   logic          mem_ack;

   logic          ir_load;
   logic          pc_inc;
   logic          pc_load;
   logic [2:0]    alu_op;
   logic          rf_we;
   logic          wb_sel;
   logic          mem_req;
   logic          mem_we;
   logic          busy;
   logic          done;
   logic          fault;
   logic [2:0]    state;
   logic [CW-1:0] retired;

   // Memory handshake: mem_req (with mem_we as store qualifier) stays high every
   // cycle until a rising edge samples mem_ack=1; ack may come with the first req.
   modport master (
      input  start, instr, zero, mem_ack,
      output ir_load, pc_inc, pc_load, alu_op, rf_we, wb_sel,
             mem_req, mem_we, busy, done, fault, state, retired
   );

   modport slave (
      output start, instr, zero, mem_ack,
      input  ir_load, pc_inc, pc_load, alu_op, rf_we, wb_sel,
             mem_req, mem_we, busy, done, fault, state, retired
   );

endinterface

// File: rtl/proc_ctrl_fsm_mem_wait_timer.sv
// Counts MEM cycles spent without an ack; expired flags the last allowed cycle.
module proc_ctrl_fsm_mem_wait_timer #(
   parameter int MEM_TIMEOUT = 8
) (
   input  logic Clk,
   input  logic Reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   logic [TW-1:0] count;

   assign expired = (count == TW'(MEM_TIMEOUT - 1));

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + TW'(1);
      end
   end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/exec/mem/writeback, handshakes
// with data memory and counts retired instructions.
module proc_ctrl_fsm
   import proc_ctrl_fsm_pkg::*;
#(
   parameter int IW          = 9,
   parameter int MEM_TIMEOUT = 8,
   parameter int CW          = 16
) (
   input  logic            Clk,
   input  logic            Reset,
   proc_ctrl_fsm_if.master bus
);

   ctrl_state_e   state;
   op_mne         opcode;
   logic [CW-1:0] retired;
   logic          timerClear;
   logic          timerEnable;
   logic          timerExpired;

   assign timerClear  = (state == ST_EXEC);
   assign timerEnable = (state == ST_MEM) && !bus.mem_ack;

   proc_ctrl_fsm_mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timer (
      .Clk    (Clk),
      .Reset  (Reset),
      .clear  (timerClear),
      .enable (timerEnable),
      .expired(timerExpired)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state   <= ST_IDLE;
         opcode  <= OP_ADD;
         retired <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) state <= ST_FETCH;
            end
            ST_FETCH: begin
               opcode <= op_mne'(bus.instr[IW-1:IW-3]);
               state  <= ST_DECODE;
            end
            ST_DECODE: begin
               state <= (opcode == kHALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
               if (isAluOp(opcode)) begin
                  state <= ST_WB;
               end else if (opcode == OP_LD || opcode == OP_SW) begin
                  state <= ST_MEM;
               end else begin
                  // BNE completes here; pc_load already chose the next PC.
                  state   <= ST_FETCH;
                  retired <= retired + CW'(1);
               end
            end
            ST_MEM: begin
               if (bus.mem_ack) begin
                  if (opcode == OP_SW) begin
                     state   <= ST_FETCH;
                     retired <= retired + CW'(1);
                  end else begin
                     state <= ST_WB;
                  end
               end else if (timerExpired) begin
                  state <= ST_FAULT;
               end
            end
            ST_WB: begin
               state   <= ST_FETCH;
               retired <= retired + CW'(1);
            end
            ST_HALT: begin
               if (bus.start) state <= ST_FETCH;
            end
            default: begin
               state <= ST_FAULT;
            end
         endcase
      end
   end

   // Outputs depend only on state/opcode, plus zero for the branch decision.
   always_comb begin
      bus.ir_load = 1'b0;
      bus.pc_inc  = 1'b0;
      bus.pc_load = 1'b0;
      bus.alu_op  = kALU_ADD;
      bus.rf_we   = 1'b0;
      bus.wb_sel  = kWB_ALU;
      bus.mem_req = 1'b0;
      bus.mem_we  = 1'b0;
      case (state)
         ST_FETCH: begin
            bus.ir_load = 1'b1;
            bus.pc_inc  = 1'b1;
         end
         ST_EXEC: begin
            if (isAluOp(opcode)) begin
               bus.alu_op = opcode;
            end else if (opcode == OP_BNE) begin
               bus.alu_op  = kALU_XOR;
               bus.pc_load = ~bus.zero;
            end
         end
         ST_MEM: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = (opcode == OP_SW);
         end
         ST_WB: begin
            bus.rf_we  = 1'b1;
            bus.wb_sel = (opcode == OP_LD) ? kWB_MEM : kWB_ALU;
         end
         default: begin
         end
      endcase
   end

   assign bus.busy    = (state != ST_IDLE) && (state != ST_HALT) && (state != ST_FAULT);
   assign bus.done    = (state == ST_HALT);
   assign bus.fault   = (state == ST_FAULT);
   assign bus.state   = state;
   assign bus.retired = retired;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Bench for proc_ctrl_fsm: per-instruction cycle traces built from the ISA timing
// rules, drained cycle by cycle against the DUT.
module tb_proc_ctrl_fsm;

   localparam int IW          = 9;
   localparam int CW          = 16;
   localparam int MEM_TIMEOUT = 8;

   localparam int S_IDLE  = 0;
   localparam int S_FETCH = 1;
   localparam int S_DEC   = 2;
   localparam int S_EXEC  = 3;
   localparam int S_MEM   = 4;
   localparam int S_WB    = 5;
   localparam int S_HALT  = 6;
   localparam int S_FAULT = 7;

   logic Clk   = 1'b0;
   logic Reset = 1'b0;

   proc_ctrl_fsm_if #(.IW(IW), .CW(CW)) bus ();

   proc_ctrl_fsm #(
      .IW         (IW),
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CW         (CW)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus)
   );

   always #5 Clk = ~Clk;

   // exp word: {ir_load,pc_inc,pc_load,alu_op,rf_we,wb_sel,mem_req,mem_we,busy,done,fault,state,retired}
   logic [31:0]   exp_q[$];
   // stim word: {start, instr, zero, mem_ack}
   logic [11:0]   stim_q[$];
   logic [CW-1:0] refRetired;
   int            nCompared = 0;
   int            nMismatch = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatch++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [31:0] mk(input int st, input logic irl, input logic pci,
                                      input logic pcl, input logic [2:0] alu, input logic rfwe,
                                      input logic wbs, input logic mreq, input logic mwe);
      logic busyE;
      busyE = (st >= S_FETCH) && (st <= S_WB);
      return {irl, pci, pcl, alu, rfwe, wbs, mreq, mwe, busyE,
              (st == S_HALT), (st == S_FAULT), 3'(st), refRetired};
   endfunction

   function automatic logic [31:0] dutWord();
      return {bus.ir_load, bus.pc_inc, bus.pc_load, bus.alu_op, bus.rf_we, bus.wb_sel,
              bus.mem_req, bus.mem_we, bus.busy, bus.done, bus.fault, bus.state, bus.retired};
   endfunction

   task automatic push(input logic [11:0] s, input logic [31:0] e);
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   // n idle/halt cycles with start=0, then one with start=1
   task automatic addWait(input int st, input int n);
      for (int i = 0; i < n; i++)
         push({1'b0, 9'($urandom), rb(), rb()}, mk(st, 0, 0, 0, 3'b000, 0, 0, 0, 0));
      push({1'b1, 9'($urandom), rb(), rb()}, mk(st, 0, 0, 0, 3'b000, 0, 0, 0, 0));
   endtask

   // One instruction starting in FETCH; waitN = MEM cycles without ack.
   task automatic addInstr(input int op, input int waitN, input logic z);
      logic [8:0] iw;
      logic [2:0] alu;
      iw = {3'(op), 6'($urandom_range(0, 63))};
      push({rb(), iw, rb(), rb()}, mk(S_FETCH, 1, 1, 0, 3'b000, 0, 0, 0, 0));
      push({rb(), 9'($urandom), rb(), rb()}, mk(S_DEC, 0, 0, 0, 3'b000, 0, 0, 0, 0));
      if (op == 7) return;
      alu = (op < 4) ? 3'(op) : ((op == 6) ? 3'b011 : 3'b000);
      push({rb(), 9'($urandom), z, rb()},
           mk(S_EXEC, 0, 0, (op == 6) && !z, alu, 0, 0, 0, 0));
      if (op == 6) begin
         refRetired++;
         return;
      end
      if (op == 4 || op == 5) begin
         for (int i = 0; i < waitN && i < MEM_TIMEOUT; i++)
            push({rb(), 9'($urandom), rb(), 1'b0}, mk(S_MEM, 0, 0, 0, 3'b000, 0, 0, 1, op == 5));
         if (waitN >= MEM_TIMEOUT) return;
         push({rb(), 9'($urandom), rb(), 1'b1}, mk(S_MEM, 0, 0, 0, 3'b000, 0, 0, 1, op == 5));
         if (op == 5) begin
            refRetired++;
            return;
         end
      end
      push({rb(), 9'($urandom), rb(), rb()}, mk(S_WB, 0, 0, 0, 3'b000, 1, op == 4, 0, 0));
      refRetired++;
   endtask

   task automatic drainN(input string tag, input int n);
      logic [11:0] s;
      logic [31:0] e;
      for (int i = 0; i < n && exp_q.size() > 0; i++) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         @(negedge Clk);
         bus.start   = s[11];
         bus.instr   = s[10:2];
         bus.zero    = s[1];
         bus.mem_ack = s[0];
         #1;
         chk(tag, dutWord(), e);
      end
   endtask

   task automatic drain(input string tag);
      drainN(tag, 1000000);
   endtask

   initial begin
      int op;
      refRetired  = '0;
      bus.start   = 1'b1;
      bus.instr   = '1;
      bus.zero    = 1'b1;
      bus.mem_ack = 1'b1;
      @(negedge Clk);
      #1;
      chk("reset_outputs", dutWord(), 32'h0);
      bus.start = 1'b0;
      Reset     = 1'b1;

      addWait(S_IDLE, 3);
      addInstr(3, 0, 1'b0);
      drain("xor");
      addInstr(4, 2, 1'b0);
      drain("ld_wait2");
      addInstr(5, 0, 1'b0);
      drain("sw_ack0");
      addInstr(6, 0, 1'b0);
      drain("bne_z0");
      addInstr(6, 0, 1'b1);
      drain("bne_z1");
      addInstr(4, MEM_TIMEOUT - 1, 1'b0);
      drain("ld_wait_max");
      addInstr(7, 0, 1'b0);
      addWait(S_HALT, 2);
      drain("halt_resume");

      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(0, 7));
         addInstr(op, int'($urandom_range(0, MEM_TIMEOUT - 1)), rb());
         if (op == 7) addWait(S_HALT, int'($urandom_range(0, 2)));
         drain("random");
      end

      // abort an LD while it waits in MEM
      addInstr(4, 5, 1'b0);
      addInstr(0, 0, 1'b0);
      drainN("pre_reset", 6);
      #1;
      Reset = 1'b0;
      #1;
      chk("reset_async", dutWord(), 32'h0);
      exp_q.delete();
      stim_q.delete();
      refRetired  = '0;
      bus.start   = 1'b1;
      bus.mem_ack = 1'b1;
      @(negedge Clk);
      #1;
      chk("reset_held", dutWord(), 32'h0);
      bus.start = 1'b0;
      Reset     = 1'b1;

      addWait(S_IDLE, 4);
      addInstr(1, 0, 1'b0);
      drain("post_reset");

      addInstr(4, MEM_TIMEOUT, 1'b0);
      for (int i = 0; i < 4; i++)
         push({1'b1, 9'($urandom), rb(), rb()}, mk(S_FAULT, 0, 0, 0, 3'b000, 0, 0, 0, 0));
      drain("mem_timeout");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
